mux_valid: RTL

Two-lane to one-lane valid-qualified multiplexer. It is the recombining counterpart of `demux_valid`: it takes the two 4-bit streams that `demux_valid` splits (`data_out0/valid_out0`, `data_out1/valid_out1`) and merges them back onto a single registered stream. Each lane has a small FIFO to absorb simultaneous arrivals, and a round-robin arbiter drains the FIFOs at one word per cycle. It sits downstream of `demux_valid` in the same `BancoPrueba` style bench.

---
 rtl/mux_valid.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mux_valid.sv
// mux_valid: merges two valid-qualified lanes through per-lane FIFOs and a round-robin arbiter.
// Latency 2 edges; no backpressure: a word hitting a full, un-popped FIFO is dropped and sets a sticky overflow.

module mux_valid_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign do_pop   = pop_vld && (count != '0);
  // A full FIFO still takes a word when its head leaves on the same edge.
  assign accept   = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (accept && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (!accept && do_pop) begin
        count <= count - CNT_ONE;
      end
    end
  end
endmodule

module mux_valid #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in0,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic                  valid_in1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  lane_out,
  output logic                  overflow0,
  output logic                  overflow1,
  output logic                  empty
);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]         count0;
  logic [CW-1:0]         count1;
  logic [DATA_WIDTH-1:0] head0;
  logic [DATA_WIDTH-1:0] head1;
  logic                  full0;
  logic                  full1;
  logic                  last;
  logic                  pop_vld;
  logic                  pop_lane;
  logic                  pop0;
  logic                  pop1;
  logic [DATA_WIDTH-1:0] pop_dat;

  mux_valid_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk      (clk),
    .reset    (reset),
    .push_vld (valid_in0),
    .push_dat (data_in0),
    .pop_vld  (pop0),
    .head_dat (head0),
    .count    (count0),
    .full     (full0)
  );

  mux_valid_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk      (clk),
    .reset    (reset),
    .push_vld (valid_in1),
    .push_dat (data_in1),
    .pop_vld  (pop1),
    .head_dat (head1),
    .count    (count1),
    .full     (full1)
  );

  // Round-robin: on a tie the lane that did not win last time is served.
  always_comb begin
    pop_vld  = 1'b0;
    pop_lane = 1'b0;
    if ((count0 != '0) && (count1 != '0)) begin
      pop_vld  = 1'b1;
      pop_lane = ~last;
    end else if (count0 != '0) begin
      pop_vld  = 1'b1;
      pop_lane = 1'b0;
    end else if (count1 != '0) begin
      pop_vld  = 1'b1;
      pop_lane = 1'b1;
    end
  end

  assign pop0    = pop_vld && !pop_lane;
  assign pop1    = pop_vld && pop_lane;
  assign pop_dat = pop_lane ? head1 : head0;
  assign empty   = (count0 == '0) && (count1 == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= 1'b0;
      last      <= 1'b1;
    end else if (pop_vld) begin
      data_out  <= pop_dat;
      valid_out <= 1'b1;
      lane_out  <= pop_lane;
      last      <= pop_lane;
    end else begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow0 <= 1'b0;
      overflow1 <= 1'b0;
    end else begin
      if (valid_in0 && full0 && !pop0) begin
        overflow0 <= 1'b1;
      end
      if (valid_in1 && full1 && !pop1) begin
        overflow1 <= 1'b1;
      end
    end
  end
endmodule
